// File: rtl/fft_out_reorder.sv
//----------------------------------------------------------------------------
// fft_out_reorder
//
// Output reorder buffer for the last FFT stage. Each incoming frame is
// captured into one half of a ping-pong RAM at its (optionally bit-reversed)
// index. Every completed frame is replayed as one gap-free burst in natural
// bin order, with start/end-of-frame markers.
//
// Ports:
//   iclk   in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   ien    in   input sample valid
//   iaddr  in   input sample index [N_STG-1:0]
//   idata  in   input sample {re, im} [DW-1:0]
//   oen    out  output sample valid
//   oaddr  out  natural-order bin index [N_STG-1:0]
//   odata  out  output sample [DW-1:0]
//   osop   out  high with bin 0 of a burst
//   oeop   out  high with bin L-1 of a burst
//   oerr   out  one-cycle pulse on a frame resync
//   oovf   out  sticky overflow flag
//   omag   out  re*re + im*im [DW-1:0] (only with FFT_REORDER_MAG_EN)
//
// Build option: define FFT_REORDER_MAG_EN to add omag and one extra
// output pipeline stage (latency T+3 instead of T+2).
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module fft_out_reorder #(
    parameter int unsigned N_STG   = 3,
    parameter int unsigned DW      = 32,
    parameter int unsigned BIT_REV = 1
) (
    input  logic             iclk,
    input  logic             rst_n,
    input  logic             ien,
    input  logic [N_STG-1:0] iaddr,
    input  logic [DW-1:0]    idata,
    output logic             oen,
    output logic [N_STG-1:0] oaddr,
    output logic [DW-1:0]    odata,
    output logic             osop,
    output logic             oeop,
    output logic             oerr,
    output logic             oovf
`ifdef FFT_REORDER_MAG_EN
    ,
    output logic [DW-1:0]    omag
`endif
);

    localparam int unsigned L = 1 << N_STG;

    typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

    function automatic logic [N_STG-1:0] bitrev(input logic [N_STG-1:0] a);
        logic [N_STG-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_STG; i++) r[i] = a[N_STG-1-i];
        return r;
    endfunction

    logic [DW-1:0]    mem [0:2*L-1];
    logic [DW-1:0]    ram_q;

    logic             wbank_q, wbank_d;
    logic [N_STG-1:0] wcnt_q, wcnt_d;
    logic [1:0]       full_q, full_d;
    logic             oerr_q, oerr_d;
    logic             ovf_q;
    logic             resync, frame_done, ovf_set;
    logic [N_STG-1:0] waddr;

    rd_state_e        state_q, state_d;
    logic             rbank_q, rbank_d;
    logic [N_STG-1:0] raddr_q, raddr_d;
    logic             rd_issue, clr_full, load, load_bank;

    logic             rv_q;
    logic [N_STG-1:0] ra_q;
    logic             s2_en_q, s2_sop_q, s2_eop_q;
    logic [N_STG-1:0] s2_addr_q;
    logic [DW-1:0]    s2_data_q;

    // ---------------- write side ----------------
    always_comb begin
        resync     = ien && (iaddr == '0) && (wcnt_q != '0);
        frame_done = ien && !resync && (wcnt_q == '1);
        waddr      = (BIT_REV != 0) ? bitrev(iaddr) : iaddr;
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        oerr_d     = 1'b0;
        if (ien) begin
            if (resync) begin
                wcnt_d = N_STG'(1);
                oerr_d = 1'b1;
            end else if (frame_done) begin
                wcnt_d  = '0;
                wbank_d = ~wbank_q;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    // ---------------- read FSM ----------------
    // IDLE also looks at a frame completing this very edge, so the first
    // read is issued one cycle after the last write (first oen at T+2).
    always_comb begin
        state_d   = state_q;
        rbank_d   = rbank_q;
        raddr_d   = raddr_q;
        rd_issue  = 1'b0;
        clr_full  = 1'b0;
        load      = 1'b0;
        // Both banks full: the bank about to be written is the older one.
        load_bank = (full_q == 2'b11) ? wbank_q :
                    (full_q != 2'b00) ? full_q[1] : wbank_q;
        case (state_q)
            RD_IDLE: begin
                if ((full_q != 2'b00) || frame_done) begin
                    load    = 1'b1;
                    state_d = RD_READ;
                    rbank_d = load_bank;
                    raddr_d = '0;
                end
            end
            RD_READ: begin
                rd_issue = 1'b1;
                raddr_d  = raddr_q + 1'b1;
                if (raddr_q == '1) begin
                    clr_full = 1'b1;
                    state_d  = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Overflow: the other bank still holds an unread frame; drop it.
    always_comb begin
        ovf_set = frame_done && full_q[~wbank_q] &&
                  !((state_q == RD_READ) && (rbank_q == ~wbank_q)) &&
                  !(load && (load_bank == ~wbank_q));
        full_d = full_q;
        if (clr_full)   full_d[rbank_q]  = 1'b0;
        if (ovf_set)    full_d[~wbank_q] = 1'b0;
        if (frame_done) full_d[wbank_q]  = 1'b1;
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q <= 1'b0;
            wcnt_q  <= '0;
            full_q  <= '0;
            oerr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= RD_IDLE;
            rbank_q <= 1'b0;
            raddr_q <= '0;
        end else begin
            wbank_q <= wbank_d;
            wcnt_q  <= wcnt_d;
            full_q  <= full_d;
            oerr_q  <= oerr_d;
            ovf_q   <= ovf_q | ovf_set;
            state_q <= state_d;
            rbank_q <= rbank_d;
            raddr_q <= raddr_d;
        end
    end

    // ---------------- RAM (no reset) ----------------
    always_ff @(posedge iclk) begin
        if (ien)      mem[{wbank_q, waddr}] <= idata;
        if (rd_issue) ram_q <= mem[{rbank_q, raddr_q}];
    end

    // ---------------- output pipeline ----------------
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q      <= 1'b0;
            ra_q      <= '0;
            s2_en_q   <= 1'b0;
            s2_sop_q  <= 1'b0;
            s2_eop_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
        end else begin
            rv_q     <= rd_issue;
            ra_q     <= raddr_q;
            s2_en_q  <= rv_q;
            s2_sop_q <= rv_q && (ra_q == '0);
            s2_eop_q <= rv_q && (ra_q == '1);
            if (rv_q) begin
                s2_addr_q <= ra_q;
                s2_data_q <= ram_q;
            end
        end
    end

    assign oerr = oerr_q;
    assign oovf = ovf_q;

`ifdef FFT_REORDER_MAG_EN
    logic signed [DW/2-1:0] re_h, im_h;
    logic signed [DW-1:0]   re_x, im_x, re_sq, im_sq;
    logic [DW-1:0]          mag_c;
    logic                   o3_en_q, o3_sop_q, o3_eop_q;
    logic [N_STG-1:0]       o3_addr_q;
    logic [DW-1:0]          o3_data_q, o3_mag_q;

    // The sum of two squared DW/2-bit signed values always fits in DW bits.
    always_comb begin
        re_h  = s2_data_q[DW-1:DW/2];
        im_h  = s2_data_q[DW/2-1:0];
        re_x  = {{(DW/2){re_h[DW/2-1]}}, re_h};
        im_x  = {{(DW/2){im_h[DW/2-1]}}, im_h};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        mag_c = $unsigned(re_sq) + $unsigned(im_sq);
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            o3_en_q   <= 1'b0;
            o3_sop_q  <= 1'b0;
            o3_eop_q  <= 1'b0;
            o3_addr_q <= '0;
            o3_data_q <= '0;
            o3_mag_q  <= '0;
        end else begin
            o3_en_q  <= s2_en_q;
            o3_sop_q <= s2_sop_q;
            o3_eop_q <= s2_eop_q;
            if (s2_en_q) begin
                o3_addr_q <= s2_addr_q;
                o3_data_q <= s2_data_q;
                o3_mag_q  <= mag_c;
            end
        end
    end

    assign oen   = o3_en_q;
    assign osop  = o3_sop_q;
    assign oeop  = o3_eop_q;
    assign oaddr = o3_addr_q;
    assign odata = o3_data_q;
    assign omag  = o3_mag_q;
`else
    assign oen   = s2_en_q;
    assign osop  = s2_sop_q;
    assign oeop  = s2_eop_q;
    assign oaddr = s2_addr_q;
    assign odata = s2_data_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
`timescale 1ns/1ps
module tb_fft_out_reorder;
    localparam int N  = 3;
    localparam int L  = 8;
    localparam int DW = 32;
`ifdef FFT_REORDER_MAG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          iclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ien = 1'b0;
    logic [N-1:0]  iaddr = '0;
    logic [DW-1:0] idata = '0;
    logic          oen, osop, oeop, oerr, oovf;
    logic [N-1:0]  oaddr;
    logic [DW-1:0] odata;
`ifdef FFT_REORDER_MAG_EN
    logic [DW-1:0] omag;
`endif

    fft_out_reorder #(.N_STG(N), .DW(DW), .BIT_REV(1)) dut (
        .iclk(iclk), .rst_n(rst_n), .ien(ien), .iaddr(iaddr), .idata(idata),
        .oen(oen), .oaddr(oaddr), .odata(odata), .osop(osop), .oeop(oeop),
        .oerr(oerr), .oovf(oovf)
`ifdef FFT_REORDER_MAG_EN
        , .omag(omag)
`endif
    );

    always #5 iclk = ~iclk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [N-1:0]  a;
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        longint        m;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    logic [DW-1:0] frame [L];
    int            cnt = 0;
    int            exp_err_n = 0;
    int            err_seen = 0;
    bit            err_flag = 0;
    time           t_done = 0, t_sop = 0, t_eop = 0, last_gap = 0;
    longint        first_mag = 0;

    // Natural bin k holds the sample that arrived with index bitrev(k).
    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < N; i++) if ((k >> i) & 1) r |= 1 << (N - 1 - i);
        return r;
    endfunction

    function automatic longint mag_of(input logic [DW-1:0] d);
        longint re, im;
        re = longint'($signed(d[DW-1:DW/2]));
        im = longint'($signed(d[DW/2-1:0]));
        return re * re + im * im;
    endfunction

    task automatic put(input bit en, input int a, input logic [DW-1:0] d);
        exp_t x;
        ien = en; iaddr = N'(a); idata = d;
        @(posedge iclk);
        if (en) begin
            if (a == 0 && cnt != 0) begin
                cnt = 0;
                err_flag = 1;
                exp_err_n++;
            end
            frame[a] = d;
            cnt++;
            if (cnt == L) begin
                cnt = 0;
                t_done = $time;
                for (int k = 0; k < L; k++) begin
                    x.a   = N'(k);
                    x.d   = frame[rev(k)];
                    x.sop = (k == 0);
                    x.eop = (k == L - 1);
                    x.m   = mag_of(x.d);
                    q.push_back(x);
                end
            end
        end
        #1;
        ien = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge iclk);
            n++;
        end
        @(negedge iclk);
        #1;
        chk(nm, q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge iclk) begin
        if (oerr || err_flag) begin
            chk("oerr_pulse", oerr, err_flag);
            if (oerr) err_seen++;
            err_flag = 0;
        end
        if (oen) begin
            if (osop) begin
                last_gap = $time - t_eop;
                t_sop = $time;
`ifdef FFT_REORDER_MAG_EN
                first_mag = omag;
`endif
            end
            if (oeop) t_eop = $time;
            if (q.size() == 0) begin
                chk("unexpected_oen", 1, 0);
            end else begin
                e = q.pop_front();
                chk("oaddr", oaddr, e.a);
                chk("odata", odata, e.d);
                chk("sop_eop", {osop, oeop}, {e.sop, e.eop});
`ifdef FFT_REORDER_MAG_EN
                chk("omag", omag, e.m);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int np;
        bit found;

        repeat (3) @(negedge iclk);
        #1;
        chk("rst_oen", oen, 0);
        chk("rst_oaddr", oaddr, 0);
        chk("rst_odata", odata, 0);
        chk("rst_sop_eop", {osop, oeop}, 0);
        chk("rst_oerr", oerr, 0);
        chk("rst_oovf", oovf, 0);
        rst_n = 1'b1;
        @(negedge iclk);
        #1;

        // 1: natural-order frame, re = iaddr -> burst re is bit-reversed bin
`ifdef FFT_REORDER_MAG_EN
        put(1, 0, {16'hFFFD, 16'd4});
`else
        put(1, 0, {16'd0, 16'd0});
`endif
        for (int i = 1; i < L; i++) put(1, i, {16'(i), 16'd0});
        drain("t1_drain");
        chk("t1_latency", longint'(t_sop - t_done), LAT * 10 + 5);
`ifdef FFT_REORDER_MAG_EN
        chk("t1_mag_bin0", first_mag, 25);
`endif

        // 2: two frames back-to-back, no input gap
        for (int i = 0; i < 2 * L; i++) put(1, i % L, $urandom);
        drain("t2_drain");
        chk("t2_gap", longint'(last_gap), 20);
        chk("t2_oovf", oovf, 0);

        // 3: ien toggling every other cycle
        for (int i = 0; i < L; i++) begin
            put(1, i, {16'(i), 16'(L - i)});
            put(0, 0, '0);
        end
        drain("t3_drain");
        chk("t3_latency", longint'(t_sop - t_done), LAT * 10 + 5);

        // 4: partial frame then restart
        for (int i = 0; i < 3; i++) put(1, i, $urandom);
        for (int i = 0; i < L; i++) put(1, i, $urandom);
        drain("t4_drain");
        chk("t4_oerr_count", err_seen, exp_err_n);

        // 5: reset mid-burst after bin 3
        for (int i = 0; i < L; i++) put(1, i, $urandom);
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge iclk);
            #1;
            if (oen && oaddr == 3) found = 1;
        end
        chk("t5_reach_bin3", found, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_oen_drop", oen, 0);
        q.delete();
        cnt = 0;
        err_flag = 0;
        @(negedge iclk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge iclk);
            #1;
            if (oen) seen++;
        end
        chk("t5_quiet", seen, 0);
        for (int i = 0; i < L; i++) put(1, i, $urandom);
        drain("t5_drain");

        // 6: random frames with random gaps and occasional restarts
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                np = $urandom_range(1, 5);
                for (int i = 0; i < np; i++) put(1, i, $urandom);
            end
            for (int i = 0; i < L; i++) begin
                repeat ($urandom_range(0, 2)) put(0, 0, '0);
                put(1, i, $urandom);
            end
            repeat ($urandom_range(2, 6)) put(0, 0, '0);
        end
        drain("t6_drain");
        chk("t6_oerr_count", err_seen, exp_err_n);
        chk("final_oovf", oovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
Output reorder buffer placed directly downstream of the last FFT stage. It captures the stage's (oen, oaddr, odata) result stream into a ping-pong RAM and replays each completed frame as one contiguous burst in natural bin order, with start/end-of-frame markers. This gives the measurement back end (spectrum/magnitude logic) gap-free frames with no bit-reversal to undo.

Parameters:
N_STG, `TOTAL_STAGE, log2 of FFT length; frame length L = 2^N_STG.
DW, `CPLX_WIDTH, packed complex width, {re[DW-1:DW/2], im[DW/2-1:0]}, both halves signed two's complement.
BIT_REV, 1, 1 = write address is bit-reversed iaddr; 0 = iaddr used as is.

Ports:
iclk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
ien  in  1  input sample valid, from last stage oen.
iaddr  in  N_STG  input sample index, from last stage oaddr.
idata  in  DW  input sample, from last stage odata.
oen  out  1  output sample valid.
oaddr  out  N_STG  natural-order bin index of odata.
odata  out  DW  output sample.
osop  out  1  high with bin 0 of each burst.
oeop  out  1  high with bin L-1 of each burst.
oerr  out  1  one-cycle pulse on a frame resync.
oovf  out  1  sticky overflow flag, cleared only by reset.

Behaviour:
- Reset (async assert, sync release): oen, oaddr, odata, osop, oeop, oerr, oovf = 0. wr_bank = 0, write count = 0, both bank-full flags = 0, read FSM in IDLE. RAM contents undefined.
- Write side: when ien = 1, idata is written to bank wr_bank at waddr = BIT_REV ? bitrev(iaddr) : iaddr. The write counter increments. On the write that makes count = L, set full[wr_bank], toggle wr_bank and clear count. Input gaps (ien = 0) of any length are allowed.
- Resync: if ien = 1 with iaddr = 0 while count != 0, the partial frame is discarded. Count restarts at 1 in the same bank, the sample is written, and oerr pulses for 1 cycle (registered, cycle after the edge).
- Overflow: if a frame completes while full[wr_bank ^ 1] is already set and that bank is not being read, set oovf. The new frame overwrites and the older pending frame is dropped.
- Read FSM:
  - IDLE: if any full flag is set, load rd_bank (oldest full bank; bank 0 wins a tie after reset), set raddr = 0 and go to READ.
  - READ: issue one RAM read per cycle, raddr 0..L-1, no gaps. After issuing L-1, clear full[rd_bank] and go to IDLE. IDLE may re-enter READ on the next cycle: 1 idle cycle between back-to-back bursts.
- RAM read latency is 1 cycle; outputs are registered. The last input write edge at cycle T gives the first oen at cycle T+2.
- oen runs L consecutive cycles per burst with oaddr = 0..L-1. osop is high with oaddr = 0 and oeop with oaddr = L-1. odata is held between bursts while oen = 0.
- A frame completing into one bank while the other bank is being read is normal operation: the reader finishes uninterrupted.
- Reset asserted mid-burst: oen drops immediately and all frames are discarded. No partial burst resumes after release.
- No backpressure: the consumer must accept every oen cycle.

Optional Feature:
FFT_REORDER_MAG_EN:
- Defined: adds output omag [DW-1:0], unsigned = re*re + im*im, computed full-precision with no truncation.
- One extra pipeline register is added, so oen/oaddr/odata/osop/oeop/omag all emerge at T+3, mutually aligned. omag resets to 0.
- Not defined: omag port and multiplier logic absent; latency T+2.

Test Plan:
- N_STG=3, BIT_REV=1, ien continuous 8 cycles, iaddr 0..7, idata = {16'd(iaddr), 16'd0} -> 8-cycle oen burst with oaddr 0..7 and odata re = bitrev3(oaddr), i.e. 0,4,2,6,1,5,3,7; osop on oaddr 0, oeop on oaddr 7; first oen 2 cycles after the last ien.
- Two frames back-to-back with no input gap -> two 8-cycle bursts separated by exactly 1 idle cycle, data of frame 2 intact; oovf stays 0.
- Frame with ien toggling every other cycle -> a single gap-free 8-cycle burst, same data order as the first test.
- 3 samples (iaddr 0,1,2), then iaddr = 0 restart followed by 8 good samples -> oerr pulses once; the burst contains only the restarted frame.
- rst_n low for 1 cycle mid-burst (after oaddr = 3) -> oen = 0 immediately, no further output until a new full frame is written.
- FFT_REORDER_MAG_EN defined, sample re = -3, im = 4 -> omag = 25, aligned with its oen, latency T+3.
